addr_unit: RTL and testbench

//  Parametrised address register unit for the CPU datapath: NREG address registers of ADDR_W bits,

---
 rtl/addr_unit_pkg.sv | 18 +
 rtl/addr_unit_ser.sv | 73 +++++++
 rtl/addr_unit.sv | 67 ++++++
 tb/tb_addr_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/addr_unit_pkg.sv
// Shared types and helpers for the address register unit: serialiser state
// encoding, slice-count helper and the parameter legality check.
package addr_unit_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  function automatic int nbytes(input int addr_w, input int data_w);
    return addr_w / data_w;
  endfunction

  function automatic bit params_ok(input int addr_w, input int data_w, input int nreg);
    return (data_w > 0) && (addr_w >= data_w) && ((addr_w % data_w) == 0) && (nreg >= 2);
  endfunction

endpackage

// File: rtl/addr_unit_ser.sv
// Byte serialiser: snapshots a register on load and streams it low slice first.
// Build option ADU_TRISTATE_EN: q floats ('z) whenever q_valid is low.
module addr_unit_ser
  import addr_unit_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] snap_in,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              rd_busy
);

  localparam int NB  = nbytes(ADDR_W, DATA_W);
  localparam int K_W = (NB > 1) ? $clog2(NB) : 1;

  ser_state_t        state;
  logic [ADDR_W-1:0] snap;
  logic [K_W-1:0]    k;
  logic [DATA_W-1:0] q_reg;

  // snap holds only the slices not yet shown: slice 0 goes straight to q_reg
  // on load, and each beat shifts the next slice down into the low bits.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      snap    <= '0;
      k       <= '0;
      q_reg   <= '0;
      q_valid <= 1'b0;
      rd_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            state   <= SHIFT;
            snap    <= snap_in >> DATA_W;
            k       <= '0;
            q_reg   <= snap_in[DATA_W-1:0];
            q_valid <= 1'b1;
            rd_busy <= 1'b1;
          end
        end
        SHIFT: begin
          if (k == K_W'(NB - 1)) begin
            state   <= IDLE;
            q_reg   <= '0;
            q_valid <= 1'b0;
            rd_busy <= 1'b0;
          end else begin
            k     <= k + 1'b1;
            q_reg <= snap[DATA_W-1:0];
            snap  <= snap >> DATA_W;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADU_TRISTATE_EN
  assign q = q_valid ? q_reg : {DATA_W{1'bz}};
`else
  assign q = q_reg;
`endif

endmodule

// File: rtl/addr_unit.sv
// Address register unit: NREG registers with load and inc/dec, an address-bus
// mux and a byte serialiser. Build option ADU_TRISTATE_EN selects a tri-state q.
module addr_unit
  import addr_unit_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int NREG   = 4,
  parameter int SEL_W  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [SEL_W-1:0]  wsel,
  input  logic [ADDR_W-1:0] wdata,
  input  logic              inc,
  input  logic              dec,
  input  logic [SEL_W-1:0]  isel,
  input  logic [SEL_W-1:0]  asel,
  output logic [ADDR_W-1:0] addr,
  input  logic              rd_req,
  input  logic [SEL_W-1:0]  rsel,
  output logic              rd_busy,
  output logic [DATA_W-1:0] q,
  output logic              q_valid
);

  if (!params_ok(ADDR_W, DATA_W, NREG)) begin : g_bad_params
    $error("addr_unit: ADDR_W must be a multiple of DATA_W and NREG must be >= 2");
  end

  logic [ADDR_W-1:0] regs [NREG];

  // Write beats inc/dec on the same register; inc and dec together cancel.
  // NOTE: the register array is reset explicitly because software relies on
  // all address registers reading zero after reset; this keeps it in flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (we && (wsel == SEL_W'(i))) begin
          regs[i] <= wdata;
        end else if ((isel == SEL_W'(i)) && (inc != dec)) begin
          regs[i] <= inc ? regs[i] + 1'b1 : regs[i] - 1'b1;
        end
      end
    end
  end

  assign addr = regs[asel];

  // regs[rsel] is the pre-edge value, so same-edge writes never reach the snapshot.
  addr_unit_ser #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .load    (rd_req),
    .snap_in (regs[rsel]),
    .q       (q),
    .q_valid (q_valid),
    .rd_busy (rd_busy)
  );

endmodule

// File: tb/tb_addr_unit.sv
// Scoreboard bench for addr_unit: directed stimulus pushes expected slices,
// per-instance monitors pop and compare on the falling edge.
module tb_addr_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // default instance 16/8/4
  logic        we = 0, inc = 0, dec = 0, rd_req = 0;
  logic [1:0]  wsel = 0, isel = 0, asel = 0, rsel = 0;
  logic [15:0] wdata = 0, addr;
  logic        rd_busy, q_valid;
  logic [7:0]  q;

  // sweep instance 24/8/8
  logic        b_we = 0, b_inc = 0, b_dec = 0, b_rd_req = 0;
  logic [2:0]  b_wsel = 0, b_isel = 0, b_asel = 0, b_rsel = 0;
  logic [23:0] b_wdata = 0, b_addr;
  logic        b_rd_busy, b_q_valid;
  logic [7:0]  b_q;

  logic [7:0] q_idle;
`ifdef ADU_TRISTATE_EN
  initial q_idle = 8'bz;
`else
  initial q_idle = 8'h00;
`endif

  logic [7:0] exp_q   [$];
  logic [7:0] exp_b_q [$];
  int b_busy_cycles = 0;

  addr_unit dut (
    .clk(clk), .rst(rst), .we(we), .wsel(wsel), .wdata(wdata),
    .inc(inc), .dec(dec), .isel(isel), .asel(asel), .addr(addr),
    .rd_req(rd_req), .rsel(rsel), .rd_busy(rd_busy), .q(q), .q_valid(q_valid)
  );

  addr_unit #(.ADDR_W(24), .DATA_W(8), .NREG(8)) dut_b (
    .clk(clk), .rst(rst), .we(b_we), .wsel(b_wsel), .wdata(b_wdata),
    .inc(b_inc), .dec(b_dec), .isel(b_isel), .asel(b_asel), .addr(b_addr),
    .rd_req(b_rd_req), .rsel(b_rsel), .rd_busy(b_rd_busy), .q(b_q), .q_valid(b_q_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reg(input string name, input logic [1:0] sel, input logic [15:0] exp);
    asel = sel;
    #1;
    check(name, addr, exp);
  endtask

  // Monitor for the default instance
  always @(negedge clk) begin
    check("busy_eq_valid", rd_busy, q_valid);
    if (q_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_slice: got 0x%0h, expected no slice at %0t", q, $time);
      end else begin
        check("slice", q, exp_q.pop_front());
      end
    end else begin
      check("q_idle", q, q_idle);
    end
  end

  // Monitor for the sweep instance
  always @(negedge clk) begin
    if (b_rd_busy) b_busy_cycles++;
    check("b_busy_eq_valid", b_rd_busy, b_q_valid);
    if (b_q_valid) begin
      if (exp_b_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL b_unexpected_slice: got 0x%0h, expected no slice at %0t", b_q, $time);
      end else begin
        check("b_slice", b_q, exp_b_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) check_reg("reset_reg", 2'(i), 16'h0000);

    // Load then stream 0xBEEF from reg 2
    we = 1; wsel = 2; wdata = 16'hBEEF;
    tick();
    we = 0;
    rd_req = 1; rsel = 2;
    exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
    tick();
    rd_req = 0;
    repeat (3) tick();

    // Wrap-around inc/dec and cancel
    we = 1; wsel = 1; wdata = 16'hFFFF;
    tick();
    we = 0;
    check_reg("load_ffff", 1, 16'hFFFF);
    inc = 1; isel = 1;
    tick();
    check_reg("inc_wrap", 1, 16'h0000);
    inc = 0; dec = 1;
    tick();
    check_reg("dec_wrap", 1, 16'hFFFF);
    inc = 1; dec = 1;
    tick();
    check_reg("inc_dec_cancel", 1, 16'hFFFF);
    inc = 0; dec = 0;

    // Write beats inc on the same register; different targets in parallel
    we = 1; wsel = 0; wdata = 16'h1234; inc = 1; isel = 0;
    tick();
    check_reg("we_over_inc", 0, 16'h1234);
    wdata = 16'h0042; isel = 1;
    tick();
    we = 0; inc = 0;
    check_reg("parallel_we", 0, 16'h0042);
    check_reg("parallel_inc", 1, 16'h0000);

    // Dropped request and write during SHIFT; hold rd_req to probe busy window
    we = 1; wsel = 3; wdata = 16'h00AA;
    tick();
    we = 0;
    rd_req = 1; rsel = 2;
    exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
    tick();
    we = 1; wsel = 2; wdata = 16'h5555; rsel = 3;
    tick();
    we = 0;
    tick();
    exp_q.push_back(8'hAA); exp_q.push_back(8'h00);
    tick();
    rd_req = 0;
    repeat (3) tick();
    check_reg("write_during_shift", 2, 16'h5555);

    // Reset mid-SHIFT aborts the stream
    rd_req = 1; rsel = 2;
    exp_q.push_back(8'h55);
    tick();
    rd_req = 0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_q_valid", q_valid, 1'b0);
    check("rst_busy", rd_busy, 1'b0);
    check("rst_q", q, q_idle);
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 4; i++) check_reg("post_reset_reg", 2'(i), 16'h0000);

    // Parameter sweep: 24-bit register over an 8-bit bus
    b_we = 1; b_wsel = 5; b_wdata = 24'hABCDEF;
    tick();
    b_we = 0;
    b_asel = 5;
    #1 check("b_load", b_addr, 24'hABCDEF);
    b_busy_cycles = 0;
    b_rd_req = 1; b_rsel = 5;
    exp_b_q.push_back(8'hEF); exp_b_q.push_back(8'hCD); exp_b_q.push_back(8'hAB);
    tick();
    b_rd_req = 0;
    repeat (5) tick();
    check("b_busy_cycles", b_busy_cycles, 3);

    check("pending_slices", exp_q.size(), 0);
    check("b_pending_slices", exp_b_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
